// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map and bus constants shared by the GPIO pad controller
package gpio_pkg;

  localparam int BUS_AW = 3;
  localparam int BUS_DW = 32;

  localparam logic [BUS_AW-1:0] REG_OUT  = 3'd0;
  localparam logic [BUS_AW-1:0] REG_OE   = 3'd1;
  localparam logic [BUS_AW-1:0] REG_PU   = 3'd2;
  localparam logic [BUS_AW-1:0] REG_PD   = 3'd3;
  localparam logic [BUS_AW-1:0] REG_IN   = 3'd4;
  localparam logic [BUS_AW-1:0] REG_IE   = 3'd5;
  localparam logic [BUS_AW-1:0] REG_IS   = 3'd6;
  localparam logic [BUS_AW-1:0] REG_RISE = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad input synchronizer with per-pin rising/falling edge detect
module gpio_sync_edge #(
  parameter int N_PINS = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_PINS-1:0] pad_y,
  input  logic [N_PINS-1:0] rise,
  output logic [N_PINS-1:0] in_sync,
  output logic [N_PINS-1:0] edge_evt
);

  logic [N_PINS-1:0] sync1;
  logic [N_PINS-1:0] sync2;
  logic [N_PINS-1:0] sync3;
  logic [1:0]        arm_cnt;
  logic              armed;
  logic [N_PINS-1:0] rise_hit;
  logic [N_PINS-1:0] fall_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      arm_cnt <= '0;
    end else begin
      sync1 <= pad_y;
      sync2 <= sync1;
      sync3 <= sync2;
      if (arm_cnt != 2'd3) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
    end
  end

  // Comparisons stay masked until all three stages hold real pad samples.
  assign armed    = (arm_cnt == 2'd3);
  assign rise_hit = sync2 & ~sync3;
  assign fall_hit = ~sync2 & sync3;
  assign in_sync  = sync2;
  assign edge_evt = armed ? ((rise & rise_hit) | (~rise & fall_hit)) : '0;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// rtl/gpio_pad_ctrl.sv - register block driving bidirectional pull-up/pull-down pads with edge interrupts
module gpio_pad_ctrl
  import gpio_pkg::*;
#(
  parameter int N_PINS = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              bus_valid,
  input  logic              bus_we,
  input  logic [BUS_AW-1:0] bus_addr,
  input  logic [BUS_DW-1:0] bus_wdata,
  output logic [BUS_DW-1:0] bus_rdata,
  output logic              bus_ready,
  output logic [N_PINS-1:0] pad_a,
  output logic [N_PINS-1:0] pad_en,
  output logic [N_PINS-1:0] pad_puen,
  output logic [N_PINS-1:0] pad_pden,
  input  logic [N_PINS-1:0] pad_y,
  output logic              irq
);

  logic [N_PINS-1:0] out_q;
  logic [N_PINS-1:0] oe_q;
  logic [N_PINS-1:0] pu_q;
  logic [N_PINS-1:0] pd_q;
  logic [N_PINS-1:0] ie_q;
  logic [N_PINS-1:0] is_q;
  logic [N_PINS-1:0] rise_q;
  logic [N_PINS-1:0] in_sync;
  logic [N_PINS-1:0] edge_evt;
  logic [N_PINS-1:0] wval;
  logic [N_PINS-1:0] is_clr;
  logic [N_PINS-1:0] rd_val;
  logic [BUS_DW-1:0] rd_ext;
  logic              accept;
  logic              wr_en;
  logic              wdata_unused;

  gpio_sync_edge #(
    .N_PINS (N_PINS)
  ) u_sync_edge (
    .clk      (clk),
    .resetn   (resetn),
    .pad_y    (pad_y),
    .rise     (rise_q),
    .in_sync  (in_sync),
    .edge_evt (edge_evt)
  );

  // A request seen while bus_ready is high is the tail of the one just served.
  assign accept       = bus_valid & ~bus_ready;
  assign wr_en        = accept & bus_we;
  assign wval         = bus_wdata[N_PINS-1:0];
  assign wdata_unused = ^bus_wdata;
  assign is_clr       = (wr_en && (bus_addr == REG_IS)) ? wval : '0;

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      REG_OUT:  rd_val = out_q;
      REG_OE:   rd_val = oe_q;
      REG_PU:   rd_val = pu_q;
      REG_PD:   rd_val = pd_q;
      REG_IN:   rd_val = in_sync;
      REG_IE:   rd_val = ie_q;
      REG_IS:   rd_val = is_q;
      REG_RISE: rd_val = rise_q;
      default:  rd_val = '0;
    endcase
    rd_ext = '0;
    rd_ext[N_PINS-1:0] = rd_val;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= accept;
      if (accept) begin
        bus_rdata <= bus_we ? '0 : rd_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q  <= '0;
      oe_q   <= '0;
      pu_q   <= '0;
      pd_q   <= '0;
      ie_q   <= '0;
      rise_q <= '0;
    end else if (wr_en) begin
      case (bus_addr)
        REG_OUT:  out_q  <= wval;
        REG_OE:   oe_q   <= wval;
        REG_PU:   pu_q   <= wval;
        REG_PD:   pd_q   <= wval;
        REG_IE:   ie_q   <= wval;
        REG_RISE: rise_q <= wval;
        default:  ;
      endcase
    end
  end

  // A fresh edge overrides a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_q <= '0;
      irq  <= 1'b0;
    end else begin
      is_q <= (is_q & ~is_clr) | edge_evt;
      irq  <= |(is_q & ie_q);
    end
  end

  assign pad_a    = out_q;
  assign pad_en   = ~oe_q;
  assign pad_puen = pu_q & ~pd_q & ~oe_q;
  assign pad_pden = pd_q & ~pu_q & ~oe_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb/tb_gpio_pad_ctrl.sv - directed table-driven bench for gpio_pad_ctrl
module tb_gpio_pad_ctrl;
  import gpio_pkg::*;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          bus_valid;
  logic          bus_we;
  logic [2:0]    bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ready;
  logic [N-1:0]  pad_a;
  logic [N-1:0]  pad_en;
  logic [N-1:0]  pad_puen;
  logic [N-1:0]  pad_pden;
  logic [N-1:0]  pad_y;
  logic          irq;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.N_PINS(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .pad_a     (pad_a),
    .pad_en    (pad_en),
    .pad_puen  (pad_puen),
    .pad_pden  (pad_pden),
    .pad_y     (pad_y),
    .irq       (irq)
  );

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_a;
    logic [15:0] exp_en;
    logic [15:0] exp_pu;
    logic [15:0] exp_pd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [2:0] addr, logic [31:0] wdata, logic chk_rd,
                              logic [31:0] exp_rd, logic [15:0] ea, logic [15:0] een,
                              logic [15:0] epu, logic [15:0] epd);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.exp_a = ea; v.exp_en = een; v.exp_pu = epu; v.exp_pd = epd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic bus_op(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat);
    @(negedge clk);
    bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_ready && lat < 8);
    rdata = bus_rdata;
    @(negedge clk);
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        ready_seen;

    resetn = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; pad_y = '0;

    // reset with pad_y toggling
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pad_y = ~pad_y;
    end
    check("rst pad_en", pad_en, 32'hFFFF);
    check("rst pad_a", pad_a, 32'h0);
    check("rst pad_puen", pad_puen, 32'h0);
    check("rst pad_pden", pad_pden, 32'h0);
    check("rst irq", irq, 32'h0);
    check("rst bus_ready", bus_ready, 32'h0);
    check("rst bus_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    pad_y = 16'h5A5A;
    resetn = 1'b1;
    wait_cycles(6);
    bus_op(1'b0, REG_IS, 32'h0, rd, lat);
    check("fill IS", rd, 32'h0);
    bus_op(1'b0, REG_IN, 32'h0, rd, lat);
    check("IN after fill", rd, 32'h5A5A);

    // falling-edge default detection, then W1C
    @(negedge clk);
    pad_y = 16'h3C00;
    wait_cycles(5);
    bus_op(1'b0, REG_IS, 32'h0, rd, lat);
    check("IS falling", rd, 32'h425A);
    check("irq IE=0", irq, 32'h0);
    bus_op(1'b1, REG_IS, 32'hFFFF, rd, lat);
    bus_op(1'b0, REG_IS, 32'h0, rd, lat);
    check("IS after W1C", rd, 32'h0);

    vecs.push_back(mk(1, REG_OUT, 32'h000000A5, 0, 0,        16'h00A5, 16'hFFFF, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, REG_OE,  32'h000000FF, 0, 0,        16'h00A5, 16'hFF00, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, REG_OUT, 32'h0,        1, 32'hA5,   16'h00A5, 16'hFF00, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, REG_OE,  32'h0,        1, 32'hFF,   16'h00A5, 16'hFF00, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, REG_OUT, 32'hFFFF1234, 0, 0,        16'h1234, 16'hFF00, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, REG_OUT, 32'h0,        1, 32'h1234, 16'h1234, 16'hFF00, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, REG_OE,  32'h0,        0, 0,        16'h1234, 16'hFFFF, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, REG_PU,  32'h3,        0, 0,        16'h1234, 16'hFFFF, 16'h0003, 16'h0000));
    vecs.push_back(mk(1, REG_PD,  32'h6,        0, 0,        16'h1234, 16'hFFFF, 16'h0001, 16'h0004));
    vecs.push_back(mk(0, REG_PU,  32'h0,        1, 32'h3,    16'h1234, 16'hFFFF, 16'h0001, 16'h0004));
    vecs.push_back(mk(0, REG_PD,  32'h0,        1, 32'h6,    16'h1234, 16'hFFFF, 16'h0001, 16'h0004));
    vecs.push_back(mk(1, REG_OE,  32'h1,        0, 0,        16'h1234, 16'hFFFE, 16'h0000, 16'h0004));
    vecs.push_back(mk(1, REG_OE,  32'h4,        0, 0,        16'h1234, 16'hFFFB, 16'h0001, 16'h0000));
    vecs.push_back(mk(1, REG_OE,  32'hFFFF0000, 0, 0,        16'h1234, 16'hFFFF, 16'h0001, 16'h0004));
    vecs.push_back(mk(1, REG_IN,  32'hFFFF,     0, 0,        16'h1234, 16'hFFFF, 16'h0001, 16'h0004));
    vecs.push_back(mk(0, REG_IN,  32'h0,        1, 32'h3C00, 16'h1234, 16'hFFFF, 16'h0001, 16'h0004));
    vecs.push_back(mk(0, REG_RISE,32'h0,        1, 32'h0,    16'h1234, 16'hFFFF, 16'h0001, 16'h0004));
    vecs.push_back(mk(0, REG_IE,  32'h0,        1, 32'h0,    16'h1234, 16'hFFFF, 16'h0001, 16'h0004));

    foreach (vecs[i]) begin
      bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("v%0d latency", i), lat, 32'd1);
      if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d pad_a", i), pad_a, vecs[i].exp_a);
      check($sformatf("v%0d pad_en", i), pad_en, vecs[i].exp_en);
      check($sformatf("v%0d pad_puen", i), pad_puen, vecs[i].exp_pu);
      check($sformatf("v%0d pad_pden", i), pad_pden, vecs[i].exp_pd);
      @(posedge clk); #1;
      check($sformatf("v%0d ready one-shot", i), bus_ready, 32'h0);
    end

    // rising edge on pin 0 -> IS at 3rd edge, irq one edge later
    bus_op(1'b1, REG_RISE, 32'h1, rd, lat);
    bus_op(1'b1, REG_IE, 32'h1, rd, lat);
    @(negedge clk);
    pad_y[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("edge IS[0] c%0d", k), dut.is_q[0], (k >= 3) ? 32'h1 : 32'h0);
      check($sformatf("edge irq c%0d", k), irq, (k >= 4) ? 32'h1 : 32'h0);
    end
    bus_op(1'b0, REG_IS, 32'h0, rd, lat);
    check("edge IS read", rd, 32'h1);
    bus_op(1'b1, REG_IS, 32'h1, rd, lat);
    wait_cycles(2);
    check("irq after clear", irq, 32'h0);
    @(negedge clk);
    pad_y[0] = 1'b0;
    wait_cycles(6);
    bus_op(1'b0, REG_IS, 32'h0, rd, lat);
    check("fall ignored IS", rd, 32'h0);
    check("fall ignored irq", irq, 32'h0);

    // W1C coinciding with a new rising edge
    @(negedge clk);
    pad_y[0] = 1'b1;
    wait_cycles(6);
    pad_y[0] = 1'b0;
    wait_cycles(6);
    check("pre-coincide irq", irq, 32'h1);
    pad_y[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = REG_IS; bus_wdata = 32'h1;
    @(posedge clk); #1;
    check("coincide ready", bus_ready, 32'h1);
    check("coincide IS[0]", dut.is_q[0], 32'h1);
    check("coincide irq", irq, 32'h1);
    @(negedge clk);
    bus_valid = 1'b0; bus_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("coincide irq hold %0d", k), irq, 32'h1);
    end
    bus_op(1'b0, REG_IS, 32'h0, rd, lat);
    check("coincide IS read", rd, 32'h1);

    // reset while a write is outstanding
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = REG_OUT; bus_wdata = 32'h00C3;
    #3;
    resetn = 1'b0;
    ready_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus_ready) ready_seen = 1'b1;
    end
    @(negedge clk);
    bus_valid = 1'b0; bus_we = 1'b0;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus_ready) ready_seen = 1'b1;
    end
    check("abort no ready", ready_seen, 32'h0);
    check("abort pad_a", pad_a, 32'h0);
    check("abort pad_en", pad_en, 32'hFFFF);
    bus_op(1'b0, REG_OUT, 32'h0, rd, lat);
    check("abort OUT read", rd, 32'h0);
    check("post-abort latency", lat, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
